// File: rtl/apb_bridge.sv
// apb_bridge
// Single-master APB requester in front of the timer peripheral. Converts the
// core's valid/ready load/store requests into two-phase APB transfers
// (SETUP then ACCESS), waits on pready and returns read data or an error.
// Requests outside the peripheral window, and transfers whose slave never
// raises pready within TIMEOUT ACCESS cycles, complete with rsp_err = 1 so
// the core never hangs.
//
// Ports:
//   sys_clk, sys_rst_n        clock (rising edge) and synchronous active-low reset
//   req_valid/req_ready       core request handshake
//   req_write/req_addr/req_wdata  request direction, byte address, write data
//   rsp_valid/rsp_rdata/rsp_err   one-cycle response pulse with data and error
//   busy                      high whenever the bridge is not idle
//   tim_psel/tim_penable/tim_paddr/tim_pwrite/tim_pwdata  APB request side
//   tim_prdata/tim_pready     APB completion side (pready may be combinational)
module apb_bridge #(
  parameter logic [31:0] ADDR_BASE      = 32'h1000_0000,
  parameter int          ADDR_SIZE_LOG2 = 12,
  parameter int          TIMEOUT        = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        tim_psel,
  output logic        tim_penable,
  output logic [31:0] tim_paddr,
  output logic        tim_pwrite,
  output logic [31:0] tim_pwdata,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready
);

  // The counter must be able to hold TIMEOUT itself; at least one bit wide.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] CNT_ONE = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0] TO_LIM  = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic [31:0]      paddr_q, paddr_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      pwdata_q, pwdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             addr_hit;
  logic [CNT_W:0]   cnt_inc;
  logic             timeout_hit;

  assign addr_hit = ((req_addr >> ADDR_SIZE_LOG2) == (ADDR_BASE >> ADDR_SIZE_LOG2));

  // cnt_inc is the number of pready-low ACCESS cycles including the current
  // one; reaching TIMEOUT means this cycle is the last one allowed.
  assign cnt_inc     = {1'b0, cnt_q} + CNT_ONE;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_LIM);

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (addr_hit) begin
            // APB request fields only change on a transfer that will use them.
            state_d  = SETUP;
            psel_d   = 1'b1;
            paddr_d  = req_addr;
            pwrite_d = req_write;
            pwdata_d = req_wdata;
          end else begin
            // Decode miss: answer immediately, never touch the bus.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (tim_pready) begin
          // pready takes priority over a timeout landing in the same cycle.
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? 32'h0 : tim_prdata;
        end else begin
          // Saturate rather than wrap when the timeout is disabled.
          if (!(&cnt_q)) begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
          if (timeout_hit) begin
            state_d     = RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end
        end
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= 32'h0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'h0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign tim_psel    = psel_q;
  assign tim_penable = penable_q;
  assign tim_paddr   = paddr_q;
  assign tim_pwrite  = pwrite_q;
  assign tim_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_bridge.sv
// Testbench for apb_bridge: directed transfers followed by randomized ones,
// each checked cycle by cycle against a transaction-level model that derives
// response latency, bus activity window, error and read data from the
// address window, wait-state count and timeout rules.
module tb_apb_bridge;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          WLOG = 12;
  localparam int          TO   = 16;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        tim_psel;
  logic        tim_penable;
  logic [31:0] tim_paddr;
  logic        tim_pwrite;
  logic [31:0] tim_pwdata;
  logic [31:0] tim_prdata;
  logic        tim_pready;

  int compared;
  int mismatched;

  apb_bridge #(
    .ADDR_BASE      (BASE),
    .ADDR_SIZE_LOG2 (WLOG),
    .TIMEOUT        (TO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .tim_psel    (tim_psel),
    .tim_penable (tim_penable),
    .tim_paddr   (tim_paddr),
    .tim_pwrite  (tim_pwrite),
    .tim_pwdata  (tim_pwdata),
    .tim_prdata  (tim_prdata),
    .tim_pready  (tim_pready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the bridge should be idle.
  task automatic chk_idle(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".psel"},      32'(tim_psel),  32'd0);
    chk({tag, ".penable"},   32'(tim_penable), 32'd0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  // One transfer presented at the current negedge (cycle 0 = accept cycle).
  // waits = pready-low ACCESS cycles before pready rises; waits >= TO never
  // answers in time. hold keeps req_valid high while busy so the next call
  // sees a continuously asserted request.
  task automatic txn(input string tag, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, input int waits,
                     input logic [31:0] rd, input bit hold);
    bit          hit;
    int          pen_n;
    int          rsp_c;
    bit          exp_err;
    logic [31:0] exp_rd;
    bit          sel_exp;
    bit          en_exp;

    hit = ((addr >> WLOG) == (BASE >> WLOG));
    if (!hit) begin
      pen_n = 0; rsp_c = 1; exp_err = 1'b1; exp_rd = 32'h0;
    end else if (waits >= TO) begin
      pen_n = TO; rsp_c = 2 + TO; exp_err = 1'b1; exp_rd = 32'h0;
    end else begin
      pen_n = waits + 1; rsp_c = 3 + waits; exp_err = 1'b0;
      exp_rd = wr ? 32'h0 : rd;
    end

    chk_idle({tag, ".c0"});
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    tim_pready = 1'b0;
    tim_prdata = $urandom;

    for (int c = 1; c <= rsp_c; c++) begin
      @(negedge sys_clk);
      sel_exp = hit && (c <= 1 + pen_n);
      en_exp  = hit && (c >= 2) && (c <= 1 + pen_n);
      chk({tag, ".psel"},      32'(tim_psel),    32'(sel_exp));
      chk({tag, ".penable"},   32'(tim_penable), 32'(en_exp));
      chk({tag, ".rsp_valid"}, 32'(rsp_valid),   32'(c == rsp_c));
      chk({tag, ".busy"},      32'(busy),        32'd1);
      chk({tag, ".req_ready"}, 32'(req_ready),   32'd0);
      if (sel_exp) begin
        chk({tag, ".paddr"},  tim_paddr,        addr);
        chk({tag, ".pwrite"}, 32'(tim_pwrite),  32'(wr));
        chk({tag, ".pwdata"}, tim_pwdata,       wd);
      end
      if (c == rsp_c) begin
        chk({tag, ".rsp_err"},   32'(rsp_err), 32'(exp_err));
        chk({tag, ".rsp_rdata"}, rsp_rdata,    exp_rd);
      end
      // Requests presented while busy must be ignored.
      req_valid  = hold ? 1'b1 : 1'($urandom);
      req_write  = 1'($urandom);
      req_addr   = (($urandom % 2) == 0) ? (BASE | ($urandom & 32'hFFF)) : $urandom;
      req_wdata  = $urandom;
      tim_pready = hit && (c >= 2 + waits);
      tim_prdata = tim_pready ? rd : $urandom;
    end
    @(negedge sys_clk);
  endtask

  // Reset pulse during ACCESS: bus drops, no response is ever produced.
  task automatic abort_txn(input string tag);
    chk_idle({tag, ".c0"});
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = BASE + 32'h20;
    req_wdata  = $urandom;
    tim_pready = 1'b0;
    @(negedge sys_clk);                      // SETUP
    req_valid = 1'b0;
    @(negedge sys_clk);                      // first ACCESS
    chk({tag, ".penable_pre"}, 32'(tim_penable), 32'd1);
    @(negedge sys_clk);                      // second ACCESS
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk({tag, ".psel"},      32'(tim_psel),    32'd0);
    chk({tag, ".penable"},   32'(tim_penable), 32'd0);
    chk({tag, ".req_ready"}, 32'(req_ready),   32'd1);
    chk({tag, ".busy"},      32'(busy),        32'd0);
    sys_rst_n = 1'b1;
    for (int i = 0; i < TO + 4; i++) begin
      @(negedge sys_clk);
      chk({tag, ".no_rsp"},  32'(rsp_valid), 32'd0);
      chk({tag, ".no_psel"}, 32'(tim_psel),  32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          w;
    compared   = 0;
    mismatched = 0;
    sys_rst_n  = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    tim_prdata = 32'h0;
    tim_pready = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("rst.req_ready", 32'(req_ready),   32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid),   32'd0);
    chk("rst.rsp_err",   32'(rsp_err),     32'd0);
    chk("rst.busy",      32'(busy),        32'd0);
    chk("rst.psel",      32'(tim_psel),    32'd0);
    chk("rst.penable",   32'(tim_penable), 32'd0);
    chk("rst.pwrite",    32'(tim_pwrite),  32'd0);
    chk("rst.rsp_rdata", rsp_rdata,        32'h0);
    chk("rst.paddr",     tim_paddr,        32'h0);
    chk("rst.pwdata",    tim_pwdata,       32'h0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    txn("wr0",     1'b1, 32'h1000_0000, 32'h0000_0003, 0,  32'h0,         1'b0);
    txn("rd_wait", 1'b0, 32'h1000_0008, 32'h1234_5678, 2,  32'hDEAD_BEEF, 1'b0);
    txn("miss",    1'b0, 32'h2000_0000, 32'h0,         0,  32'hFFFF_FFFF, 1'b0);
    txn("tmo",     1'b0, 32'h1000_0010, 32'h0,         TO, 32'hCAFE_F00D, 1'b0);
    txn("tmo_rdy", 1'b0, 32'h1000_0014, 32'h0,         TO - 1, 32'hCAFE_F00D, 1'b0);
    txn("edge_hi", 1'b0, 32'h1000_0FFC, 32'h0,         1,  32'h0BAD_CAFE, 1'b0);
    txn("edge_mis",1'b1, 32'h1000_1000, 32'h55AA_55AA, 0,  32'h0,         1'b0);
    abort_txn("abort");
    txn("b2b0",    1'b1, 32'h1000_0040, 32'hA5A5_0001, 0,  32'h0,         1'b1);
    txn("b2b1",    1'b1, 32'h1000_0044, 32'hA5A5_0002, 0,  32'h0,         1'b0);

    for (int n = 0; n < 40; n++) begin
      if (($urandom % 4) == 0) begin
        a = $urandom;
        if ((a >> WLOG) == (BASE >> WLOG)) a[31] = ~a[31];
      end else begin
        a = BASE | ($urandom & 32'hFFF);
      end
      w = (($urandom % 5) == 0) ? TO + int'($urandom % 3) : int'($urandom % 6);
      txn("rand", 1'($urandom), a, $urandom, w, $urandom, 1'($urandom));
    end

    req_valid = 1'b0;
    chk_idle("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
